// File: rtl/frame_task_scheduler_pkg.sv
// Shared types and defaults for the per-frame task scheduler.
// Included by the top level and the request selector.
package frame_task_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int N_REQ_DEF       = 4;
    localparam int IDX_W_DEF       = 3;
    localparam int TIMEOUT_CYC_DEF = 4096;
    localparam int FCNT_W_DEF      = 16;

    localparam int ERR_TO_BIT = 0;
    localparam int ERR_OV_BIT = 1;

endpackage

// File: rtl/frame_task_scheduler_next_req_sel.sv
// Priority encoder: lowest set mask bit at or above base.
// Base is included only when incl is high.
module frame_task_scheduler_next_req_sel
    import frame_task_scheduler_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] base,
    input  logic             incl,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(base)) ||
                            (incl && (i == int'(base))))) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_task_scheduler.sv
// Grants game-logic units one at a time during vertical blanking,
// with per-unit timeout and active-video overrun detection.
module frame_task_scheduler
    import frame_task_scheduler_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int FCNT_W      = FCNT_W_DEF
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vblnk,
    input  logic [N_REQ-1:0]  req_en,
    input  logic [N_REQ-1:0]  done,
    input  logic              clr_err,
    output logic [N_REQ-1:0]  start,
    output logic              busy,
    output logic [IDX_W-1:0]  cur_idx,
    output logic              frame_done,
    output logic              timeout,
    output logic [IDX_W-1:0]  timeout_id,
    output logic              overrun,
    output logic [1:0]        err_flag,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t state, state_n;

    logic              vblnk_d;
    logic [N_REQ-1:0]  mask, mask_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  cur_idx_n, timeout_id_n;
    logic [N_REQ-1:0]  start_n;
    logic              busy_n, frame_done_n;
    logic              timeout_n, overrun_n;
    logic [1:0]        err_flag_n;
    logic [FCNT_W-1:0] frame_cnt_n;

    logic              rise, cur_done;
    logic [IDX_W-1:0]  first_idx, next_idx;
    logic              first_vld, next_vld;

    assign rise     = vblnk & ~vblnk_d;
    assign cur_done = |(done & (N_REQ'(1) << cur_idx));

    frame_task_scheduler_next_req_sel #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_first_sel (
        .mask  (req_en),
        .base  ('0),
        .incl  (1'b1),
        .idx   (first_idx),
        .valid (first_vld)
    );

    frame_task_scheduler_next_req_sel #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_next_sel (
        .mask  (mask),
        .base  (cur_idx),
        .incl  (1'b0),
        .idx   (next_idx),
        .valid (next_vld)
    );

    always_comb begin
        state_n      = state;
        mask_n       = mask;
        cnt_n        = cnt;
        cur_idx_n    = cur_idx;
        timeout_id_n = timeout_id;
        frame_cnt_n  = frame_cnt;
        start_n      = '0;
        frame_done_n = 1'b0;
        timeout_n    = 1'b0;
        overrun_n    = 1'b0;
        err_flag_n   = clr_err ? 2'b00 : err_flag;

        unique case (state)
            IDLE: begin
                if (rise) begin
                    frame_cnt_n = frame_cnt + 1'b1;
                    mask_n      = req_en;
                    if (first_vld) begin
                        cur_idx_n = first_idx;
                        start_n   = N_REQ'(1) << first_idx;
                        state_n   = ISSUE;
                    end else begin
                        frame_done_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!vblnk) begin
                    overrun_n              = 1'b1;
                    err_flag_n[ERR_OV_BIT] = 1'b1;
                    state_n                = IDLE;
                end else begin
                    cnt_n   = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (!vblnk) begin
                    overrun_n              = 1'b1;
                    err_flag_n[ERR_OV_BIT] = 1'b1;
                    state_n                = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (cur_done || (cnt == CNT_LAST)) begin
                        if (!cur_done) begin
                            timeout_n              = 1'b1;
                            timeout_id_n           = cur_idx;
                            err_flag_n[ERR_TO_BIT] = 1'b1;
                        end
                        if (next_vld) begin
                            cur_idx_n = next_idx;
                            start_n   = N_REQ'(1) << next_idx;
                            state_n   = ISSUE;
                        end else begin
                            frame_done_n = 1'b1;
                            state_n      = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            vblnk_d    <= 1'b0;
            mask       <= '0;
            cnt        <= '0;
            cur_idx    <= '0;
            timeout_id <= '0;
            frame_cnt  <= '0;
            start      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
            err_flag   <= 2'b00;
        end else begin
            state      <= state_n;
            vblnk_d    <= vblnk;
            mask       <= mask_n;
            cnt        <= cnt_n;
            cur_idx    <= cur_idx_n;
            timeout_id <= timeout_id_n;
            frame_cnt  <= frame_cnt_n;
            start      <= start_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            timeout    <= timeout_n;
            overrun    <= overrun_n;
            err_flag   <= err_flag_n;
        end
    end

endmodule

// File: tb/tb_frame_task_scheduler.sv
// Directed bench for frame_task_scheduler: a per-cycle vector
// table for a full frame plus hand sequences for corner cases.
module tb_frame_task_scheduler;

    logic        pclk;
    logic        rst;
    logic        vblnk;
    logic [3:0]  req_en;
    logic [3:0]  done;
    logic        clr_err;
    logic [3:0]  start;
    logic        busy;
    logic [2:0]  cur_idx;
    logic        frame_done;
    logic        timeout;
    logic [2:0]  timeout_id;
    logic        overrun;
    logic [1:0]  err_flag;
    logic [15:0] frame_cnt;

    int n_chk;
    int n_fail;

    frame_task_scheduler #(
        .N_REQ       (4),
        .IDX_W       (3),
        .TIMEOUT_CYC (16),
        .FCNT_W      (16)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk      (vblnk),
        .req_en     (req_en),
        .done       (done),
        .clr_err    (clr_err),
        .start      (start),
        .busy       (busy),
        .cur_idx    (cur_idx),
        .frame_done (frame_done),
        .timeout    (timeout),
        .timeout_id (timeout_id),
        .overrun    (overrun),
        .err_flag   (err_flag),
        .frame_cnt  (frame_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic       vb;
        logic [3:0] req;
        logic [3:0] dn;
        logic [3:0] e_start;
        logic       e_busy;
        logic [2:0] e_idx;
        logic       e_fd;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b0;
        vblnk   = 1'b0;
        req_en  = 4'b0000;
        done    = 4'b0000;
        clr_err = 1'b0;

        // Frame of units 0,1,3; each answers 5 cycles after start.
        // Row 3 pulses a foreign done, row 7 a done during ISSUE.
        tbl[0]  = '{1'b1, 4'b1011, 4'b0000, 4'b0001, 1'b1, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'b1011, 4'b0100, 4'b0000, 1'b1, 3'd0, 1'b0};
        tbl[4]  = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd0, 1'b0};
        tbl[5]  = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd0, 1'b0};
        tbl[6]  = '{1'b1, 4'b1011, 4'b0001, 4'b0010, 1'b1, 3'd1, 1'b0};
        tbl[7]  = '{1'b1, 4'b1011, 4'b0010, 4'b0000, 1'b1, 3'd1, 1'b0};
        tbl[8]  = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd1, 1'b0};
        tbl[9]  = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd1, 1'b0};
        tbl[10] = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd1, 1'b0};
        tbl[11] = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd1, 1'b0};
        tbl[12] = '{1'b1, 4'b1011, 4'b0010, 4'b1000, 1'b1, 3'd3, 1'b0};
        tbl[13] = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd3, 1'b0};
        tbl[14] = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd3, 1'b0};
        tbl[15] = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd3, 1'b0};
        tbl[16] = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd3, 1'b0};
        tbl[17] = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b1, 3'd3, 1'b0};
        tbl[18] = '{1'b1, 4'b1011, 4'b1000, 4'b0000, 1'b0, 3'd3, 1'b1};
        tbl[19] = '{1'b1, 4'b1011, 4'b0000, 4'b0000, 1'b0, 3'd3, 1'b0};

        #2;
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fcnt", 32'(frame_cnt), 32'h0);
        chk("rst_err", 32'(err_flag), 32'h0);
        #10;
        rst = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 20; i++) begin
            vblnk  = tbl[i].vb;
            req_en = tbl[i].req;
            done   = tbl[i].dn;
            step();
            chk($sformatf("r%0d_start", i),
                32'(start), 32'(tbl[i].e_start));
            chk($sformatf("r%0d_busy", i),
                32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("r%0d_idx", i),
                32'(cur_idx), 32'(tbl[i].e_idx));
            chk($sformatf("r%0d_fdone", i),
                32'(frame_done), 32'(tbl[i].e_fd));
            chk($sformatf("r%0d_flags", i),
                32'({timeout, overrun, err_flag}), 32'h0);
        end
        chk("a_fcnt", 32'(frame_cnt), 32'd1);

        // Empty mask.
        vblnk = 1'b0;
        done  = 4'b0000;
        step();
        vblnk  = 1'b1;
        req_en = 4'b0000;
        step();
        chk("b_fdone", 32'(frame_done), 32'h1);
        chk("b_busy", 32'(busy), 32'h0);
        chk("b_start", 32'(start), 32'h0);
        chk("b_fcnt", 32'(frame_cnt), 32'd2);
        step();
        chk("b_fdone_end", 32'(frame_done), 32'h0);
        chk("b_busy_end", 32'(busy), 32'h0);

        // Unit 1 never answers.
        vblnk = 1'b0;
        step();
        vblnk  = 1'b1;
        req_en = 4'b0111;
        step();
        chk("c_start0", 32'(start), 32'h1);
        chk("c_fcnt", 32'(frame_cnt), 32'd3);
        step();
        done = 4'b0001;
        step();
        done = 4'b0000;
        chk("c_start1", 32'(start), 32'h2);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("c_quiet%0d", i),
                32'({timeout, start}), 32'h0);
        end
        step();
        chk("c_timeout", 32'(timeout), 32'h1);
        chk("c_to_id", 32'(timeout_id), 32'd1);
        chk("c_err", 32'(err_flag), 32'h1);
        chk("c_start2", 32'(start), 32'h4);
        chk("c_idx2", 32'(cur_idx), 32'd2);
        step();
        chk("c_to_pulse", 32'(timeout), 32'h0);
        done = 4'b0100;
        step();
        done = 4'b0000;
        chk("c_fdone", 32'(frame_done), 32'h1);
        chk("c_busy", 32'(busy), 32'h0);

        // Overrun while waiting on unit 2; its set beats a clear.
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("d_clr", 32'(err_flag), 32'h0);
        vblnk = 1'b0;
        step();
        vblnk  = 1'b1;
        req_en = 4'b1100;
        step();
        chk("d_start2", 32'(start), 32'h4);
        step();
        vblnk   = 1'b0;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("d_overrun", 32'(overrun), 32'h1);
        chk("d_err", 32'(err_flag), 32'h2);
        chk("d_busy", 32'(busy), 32'h0);
        chk("d_to_id_hold", 32'(timeout_id), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("d_drop%0d", i),
                32'({overrun, frame_done, busy, start}), 32'h0);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("d_clr2", 32'(err_flag), 32'h0);

        // Done on the last allowed cycle wins over timeout.
        vblnk  = 1'b1;
        req_en = 4'b0001;
        step();
        chk("f_start0", 32'(start), 32'h1);
        chk("f_fcnt", 32'(frame_cnt), 32'd5);
        step();
        for (int i = 0; i < 15; i++) step();
        done = 4'b0001;
        step();
        done = 4'b0000;
        chk("f_fdone", 32'(frame_done), 32'h1);
        chk("f_no_to", 32'(timeout), 32'h0);
        chk("f_err", 32'(err_flag), 32'h0);

        // Asynchronous reset mid-WAIT.
        vblnk = 1'b0;
        step();
        vblnk  = 1'b1;
        req_en = 4'b0110;
        step();
        chk("e_start1", 32'(start), 32'h2);
        step();
        #3;
        rst = 1'b0;
        #1;
        chk("e_busy", 32'(busy), 32'h0);
        chk("e_idx", 32'(cur_idx), 32'h0);
        chk("e_fcnt", 32'(frame_cnt), 32'h0);
        chk("e_to_id", 32'(timeout_id), 32'h0);
        chk("e_outs",
            32'({start, frame_done, timeout, overrun, err_flag}),
            32'h0);
        #2;
        rst = 1'b1;
        step();
        chk("e2_fcnt", 32'(frame_cnt), 32'd1);
        chk("e2_start", 32'(start), 32'h2);
        chk("e2_busy", 32'(busy), 32'h1);
        chk("e2_idx", 32'(cur_idx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
